// File: rtl/spram_req_arbiter.sv
// -----------------------------------------------------------------------------
// spram_req_arbiter
//
// Purpose:
//   Two-requester front end for the 1024x32 single-port data RAM. Grants at
//   most one read/write request per cycle onto the RAM pins. A read's
//   registered RAM output is captured one cycle after issue. It is then held
//   in a shared response register until the owning requester takes it.
//
// Optional feature (compile-time macro):
//   SPRAM_ARB_RR_EN  defined   -> round-robin tie-break using a 1-bit
//                                 last-grant pointer.
//                    undefined -> fixed priority; port0 wins every tie.
//
// Ports:
//   clk, resetn                   clock, synchronous active-low reset
//   pX_req_valid/ready            request handshake (ready = combinational grant)
//   pX_req_we/addr/data           request payload (we=1 write, we=0 read)
//   pX_rsp_valid/ready/data       held read-response channel per port
//   ram_address/ram_wren/ram_data RAM request pins
//   ram_out                       RAM registered read data
// -----------------------------------------------------------------------------
module spram_req_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          p0_req_valid,
   output logic          p0_req_ready,
   input  logic          p0_req_we,
   input  logic [AW-1:0] p0_req_addr,
   input  logic [DW-1:0] p0_req_data,
   input  logic          p1_req_valid,
   output logic          p1_req_ready,
   input  logic          p1_req_we,
   input  logic [AW-1:0] p1_req_addr,
   input  logic [DW-1:0] p1_req_data,
   output logic          p0_rsp_valid,
   input  logic          p0_rsp_ready,
   output logic [DW-1:0] p0_rsp_data,
   output logic          p1_rsp_valid,
   input  logic          p1_rsp_ready,
   output logic [DW-1:0] p1_rsp_data,
   output logic [AW-1:0] ram_address,
   output logic          ram_wren,
   output logic [DW-1:0] ram_data,
   input  logic [DW-1:0] ram_out
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PEND  = 2'd1,
      ST_FULL  = 2'd2
   } rsp_state_t;

   rsp_state_t    state_r;
   rsp_state_t    state_nxt_s;
   logic          rsp_id_r;
   logic          pend_id_r;
   logic [DW-1:0] rsp_data_r;

   logic          rsp_fire_s;
   logic          read_ok_s;
   logic          elig0_s;
   logic          elig1_s;
   logic          prio0_s;
   logic          gnt0_s;
   logic          gnt1_s;
   logic          read_acc_s;

`ifdef SPRAM_ARB_RR_EN
   logic          last_r;   // 1 = port1 was granted last

   // Tie-break favours the port that was not granted most recently
   always_comb begin
      prio0_s = last_r;
   end

   // Last-grant pointer; reset to port1 so port0 wins the first tie
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_r <= 1'b1;
      end else if (gnt0_s) begin
         last_r <= 1'b0;
      end else if (gnt1_s) begin
         last_r <= 1'b1;
      end else begin
         last_r <= last_r;
      end
   end
`else
   // Fixed priority: port0 always wins a tie
   always_comb begin
      prio0_s = 1'b1;
   end
`endif

   // Response handshake, read admission, eligibility and grant
   always_comb begin
      rsp_fire_s = 1'b0;
      if (resetn && (state_r == ST_FULL)) begin
         if (rsp_id_r) begin
            rsp_fire_s = p1_rsp_ready;
         end else begin
            rsp_fire_s = p0_rsp_ready;
         end
      end else begin
         rsp_fire_s = 1'b0;
      end

      // The response register frees up in the same cycle it is consumed,
      // so a new read may be accepted then.
      read_ok_s  = (state_r == ST_EMPTY) || rsp_fire_s;
      elig0_s    = resetn && p0_req_valid && (p0_req_we || read_ok_s);
      elig1_s    = resetn && p1_req_valid && (p1_req_we || read_ok_s);
      gnt0_s     = elig0_s && (!elig1_s || prio0_s);
      gnt1_s     = elig1_s && !gnt0_s;
      read_acc_s = (gnt0_s && !p0_req_we) || (gnt1_s && !p1_req_we);
   end

   // RAM request mux; idle cycles drive zeros (that read is never captured)
   always_comb begin
      ram_address = {AW{1'b0}};
      ram_wren    = 1'b0;
      ram_data    = {DW{1'b0}};
      if (gnt0_s) begin
         ram_address = p0_req_addr;
         ram_wren    = p0_req_we;
         ram_data    = p0_req_data;
      end else if (gnt1_s) begin
         ram_address = p1_req_addr;
         ram_wren    = p1_req_we;
         ram_data    = p1_req_data;
      end else begin
         ram_address = {AW{1'b0}};
         ram_wren    = 1'b0;
         ram_data    = {DW{1'b0}};
      end
   end

   // Handshake and response outputs
   always_comb begin
      p0_req_ready = gnt0_s;
      p1_req_ready = gnt1_s;
      p0_rsp_valid = resetn && (state_r == ST_FULL) && !rsp_id_r;
      p1_rsp_valid = resetn && (state_r == ST_FULL) && rsp_id_r;
      p0_rsp_data  = rsp_data_r;
      p1_rsp_data  = rsp_data_r;
   end

   // Response-path next state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (read_acc_s) begin
               state_nxt_s = ST_PEND;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_PEND: begin
            state_nxt_s = ST_FULL;
         end
         ST_FULL: begin
            if (rsp_fire_s && read_acc_s) begin
               state_nxt_s = ST_PEND;
            end else if (rsp_fire_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // State register, issue tag and response capture
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r    <= ST_EMPTY;
         pend_id_r  <= 1'b0;
         rsp_id_r   <= 1'b0;
         rsp_data_r <= {DW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (read_acc_s) begin
            pend_id_r <= gnt1_s;
         end else begin
            pend_id_r <= pend_id_r;
         end
         // ram_out is valid only in the cycle after issue
         if (state_r == ST_PEND) begin
            rsp_data_r <= ram_out;
            rsp_id_r   <= pend_id_r;
         end else begin
            rsp_data_r <= rsp_data_r;
            rsp_id_r   <= rsp_id_r;
         end
      end
   end

endmodule

// File: tb/tb_spram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spram_req_arbiter
//
// Directed self-checking bench for spram_req_arbiter with a behavioural model
// of the single-port RAM. The RAM commits writes at the edge and keeps its
// output on write cycles. Expected tie-break outcomes depend on
// SPRAM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_spram_req_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk;
   logic          resetn;
   logic          p0_req_valid, p0_req_ready, p0_req_we;
   logic [AW-1:0] p0_req_addr;
   logic [DW-1:0] p0_req_data;
   logic          p1_req_valid, p1_req_ready, p1_req_we;
   logic [AW-1:0] p1_req_addr;
   logic [DW-1:0] p1_req_data;
   logic          p0_rsp_valid, p0_rsp_ready;
   logic [DW-1:0] p0_rsp_data;
   logic          p1_rsp_valid, p1_rsp_ready;
   logic [DW-1:0] p1_rsp_data;
   logic [AW-1:0] ram_address;
   logic          ram_wren;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] ram_out;

   logic [DW-1:0] mem [0:1023];

   int n_cmp = 0;
   int n_err = 0;

   spram_req_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .resetn(resetn),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
      .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
      .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(p0_rsp_data),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(p1_rsp_data),
      .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
      .ram_out(ram_out)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural single-port RAM: write commits at the edge, out held on writes
   always @(posedge clk) begin
      if (ram_wren) begin
         mem[ram_address] <= ram_data;
      end else begin
         ram_out <= mem[ram_address];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_data = '0;
      p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_data = '0;
   endtask

   // Tie winner for the k-th contested slot in the bursts below (1 = port1).
   // With round-robin, port0 was granted last before each burst, so port1 leads.
   function automatic logic tie_winner(input int k);
`ifdef SPRAM_ARB_RR_EN
      return (k % 2 == 0) ? 1'b1 : 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      logic gp;
      logic rp;
      clr_req();
      p0_rsp_ready = 1'b0;
      p1_rsp_ready = 1'b0;
      resetn = 1'b0;
      #1;
      // Outputs must stay quiet while reset is asserted, even with a request
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 10'h005;
      tick();
      check_val("rst_p0_ready", {31'd0, p0_req_ready}, 32'd0);
      check_val("rst_wren", {31'd0, ram_wren}, 32'd0);
      check_val("rst_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
      check_val("rst_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
      tick();
      clr_req();
      resetn = 1'b1;
      tick();

      // Preload 0x3FF with a known old value through p1
      p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 10'h3FF; p1_req_data = 32'hA5A5A5A5;
      #1;
      check_val("preload_p1_ready", {31'd0, p1_req_ready}, 32'd1);
      tick();
      clr_req();

      // Write then read back through p0
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 10'h005; p0_req_data = 32'hDEADBEEF;
      #1;
      check_val("wr_p0_ready", {31'd0, p0_req_ready}, 32'd1);
      check_val("wr_wren", {31'd0, ram_wren}, 32'd1);
      check_val("wr_addr", {22'd0, ram_address}, 32'h005);
      check_val("wr_data", ram_data, 32'hDEADBEEF);
      tick();
      p0_req_we = 1'b0;
      #1;
      check_val("rd_p0_ready", {31'd0, p0_req_ready}, 32'd1);
      check_val("rd_wren", {31'd0, ram_wren}, 32'd0);
      tick();
      clr_req();
      #1;
      check_val("rd_pend_no_valid", {31'd0, p0_rsp_valid}, 32'd0);
      tick();
      check_val("rd_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd1);
      check_val("rd_p0_rsp_data", p0_rsp_data, 32'hDEADBEEF);
      check_val("rd_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
      p0_rsp_ready = 1'b1;
      tick();
      p0_rsp_ready = 1'b0;
      check_val("rd_drained", {31'd0, p0_rsp_valid}, 32'd0);

      // p1 read held FULL for 5 cycles: reads stall, p0 writes still go
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 10'h005;
      #1;
      check_val("hold_p1_rd_ready", {31'd0, p1_req_ready}, 32'd1);
      tick();
      p1_req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         p0_req_valid = 1'b1; p0_req_we = 1'b1;
         p0_req_addr = 10'h010 + 10'(i); p0_req_data = 32'h100 + 32'(i);
         p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 10'h011;
         #1;
         check_val($sformatf("hold_p1_valid_%0d", i), {31'd0, p1_rsp_valid}, 32'd1);
         check_val($sformatf("hold_p1_data_%0d", i), p1_rsp_data, 32'hDEADBEEF);
         check_val($sformatf("hold_p0_wr_ready_%0d", i), {31'd0, p0_req_ready}, 32'd1);
         check_val($sformatf("hold_p1_rd_stall_%0d", i), {31'd0, p1_req_ready}, 32'd0);
         tick();
      end
      clr_req();
      p1_rsp_ready = 1'b1;
      tick();
      p1_rsp_ready = 1'b0;
      check_val("hold_drained", {31'd0, p1_rsp_valid}, 32'd0);

      // Both ports read continuously with responses always taken
      p0_rsp_ready = 1'b1;
      p1_rsp_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         p0_req_valid = (k < 8); p0_req_we = 1'b0; p0_req_addr = 10'h005;
         p1_req_valid = (k < 8); p1_req_we = 1'b0; p1_req_addr = 10'h011;
         #1;
         if (k % 2 == 0) begin
            if (k >= 2) begin
               rp = tie_winner(k / 2 - 1);
               check_val($sformatf("burst_p0_rsp_valid_%0d", k), {31'd0, p0_rsp_valid}, {31'd0, !rp});
               check_val($sformatf("burst_p1_rsp_valid_%0d", k), {31'd0, p1_rsp_valid}, {31'd0, rp});
               check_val($sformatf("burst_rsp_data_%0d", k),
                         rp ? p1_rsp_data : p0_rsp_data, rp ? 32'h101 : 32'hDEADBEEF);
            end
            if (k < 8) begin
               gp = tie_winner(k / 2);
               check_val($sformatf("burst_p0_ready_%0d", k), {31'd0, p0_req_ready}, {31'd0, !gp});
               check_val($sformatf("burst_p1_ready_%0d", k), {31'd0, p1_req_ready}, {31'd0, gp});
            end
         end else begin
            check_val($sformatf("burst_pend_stall_%0d", k),
                      {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
         end
         tick();
      end
      clr_req();
      p0_rsp_ready = 1'b0;
      p1_rsp_ready = 1'b0;

      // Both ports write every cycle
      for (int k = 0; k < 4; k++) begin
         p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 10'h020; p0_req_data = 32'hAAAA0000 + 32'(k);
         p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 10'h030; p1_req_data = 32'hBBBB0000 + 32'(k);
         #1;
         gp = tie_winner(k);
         check_val($sformatf("wr2_p0_ready_%0d", k), {31'd0, p0_req_ready}, {31'd0, !gp});
         check_val($sformatf("wr2_p1_ready_%0d", k), {31'd0, p1_req_ready}, {31'd0, gp});
         check_val($sformatf("wr2_data_%0d", k), ram_data,
                   gp ? (32'hBBBB0000 + 32'(k)) : (32'hAAAA0000 + 32'(k)));
         tick();
      end
      clr_req();

      // Reset while a read is pending discards it
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 10'h005;
      tick();
      clr_req();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val($sformatf("rstpend_no_rsp_%0d", k), {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
         tick();
      end
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 10'h005;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 10'h011;
      #1;
      check_val("rstpend_tie_p0", {30'd0, p1_req_ready, p0_req_ready}, 32'd1);
      tick();
      clr_req();
      tick();
      check_val("rstpend_rsp_p0", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd1);
      check_val("rstpend_rsp_data", p0_rsp_data, 32'hDEADBEEF);
      p0_rsp_ready = 1'b1;
      tick();
      p0_rsp_ready = 1'b0;

      // Read 0x3FF, then a write to 0x3FF lands during PEND
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 10'h3FF;
      #1;
      check_val("raw_rd_ready", {31'd0, p0_req_ready}, 32'd1);
      tick();
      clr_req();
      p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 10'h3FF; p1_req_data = 32'h12345678;
      #1;
      check_val("raw_wr_in_pend", {31'd0, p1_req_ready}, 32'd1);
      tick();
      clr_req();
      p0_rsp_ready = 1'b1;
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 10'h3FF;
      #1;
      check_val("raw_old_valid", {31'd0, p0_rsp_valid}, 32'd1);
      check_val("raw_old_data", p0_rsp_data, 32'hA5A5A5A5);
      check_val("raw_rd2_ready", {31'd0, p0_req_ready}, 32'd1);
      tick();
      clr_req();
      #1;
      check_val("raw_pend2_no_valid", {31'd0, p0_rsp_valid}, 32'd0);
      tick();
      check_val("raw_new_valid", {31'd0, p0_rsp_valid}, 32'd1);
      check_val("raw_new_data", p0_rsp_data, 32'h12345678);
      tick();
      p0_rsp_ready = 1'b0;
      check_val("raw_drained", {31'd0, p0_rsp_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
